// File: rtl/multdiv_ctrl_if.sv
// Start/result bundle between pipeline control (master) and the iterative
// multiply/divide unit (slave).
interface multdiv_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply / divide sequencer over one shared adder, WIDTH+3 cycle latency.
// Optional: MULTDIV_EARLY_ZERO_EN finishes zero-operand operations straight from SETUP.
module multdiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  multdiv_ctrl_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] IntMin = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StSetup, StRun, StFixup, StDone} state_e;

  state_e             state_q;
  logic               div_q, sign_q, div0_q, ovf_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     rem_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q, rdy_q, busy_q;

  logic               start;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_x, add_y;
  logic               add_cin;
  logic [WIDTH+1:0]   add_sum;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH:0]     prod_top;
  logic               mult_ovf;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;

  // Shared adder: negation in SETUP/FIXUP, accumulate (MULT) or trial subtract (DIV) in RUN.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (state_q)
      StSetup: begin
        add_x   = {1'b0, ~a_q};
        add_cin = 1'b1;
      end
      StRun: begin
        if (div_q) begin
          add_x   = rem_q;
          add_y   = ~{1'b0, b_q};
          add_cin = 1'b1;
        end else begin
          add_x = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
          add_y = prod_q[0] ? {1'b0, a_q} : '0;
        end
      end
      StFixup: begin
        add_x   = {1'b0, ~prod_q[WIDTH-1:0]};
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};

  assign abs_a = a_q[WIDTH-1] ? add_sum[WIDTH-1:0] : a_q;
  assign abs_b = b_q[WIDTH-1] ? (~b_q + {{(WIDTH-1){1'b0}}, 1'b1}) : b_q;

  assign prod_signed = sign_q ? (~prod_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_q;
  assign prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
  assign mult_ovf    = ~((&prod_top) | ~(|prod_top));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      div_q    <= 1'b0;
      sign_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (start) begin
      // A start in any state (re)launches; an aborted operation never reports.
      state_q <= StSetup;
      div_q   <= ~bus.ctrl_MULT;
      a_q     <= bus.data_operandA;
      b_q     <= bus.data_operandB;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        StSetup: begin
          sign_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          div0_q  <= (b_q == '0);
          ovf_q   <= (a_q == IntMin) && (&b_q);
          a_q     <= abs_a;
          b_q     <= abs_b;
          // DIV: rem holds the next trial operand; dividend bits queue up in prod low word.
          rem_q   <= {{WIDTH{1'b0}}, abs_a[WIDTH-1]};
          prod_q  <= div_q ? {{WIDTH{1'b0}}, abs_a[WIDTH-2:0], 1'b0}
                           : {{WIDTH{1'b0}}, abs_b};
          state_q <= StRun;
`ifdef MULTDIV_EARLY_ZERO_EN
          if ((a_q == '0) || (b_q == '0)) begin
            result_q <= '0;
            exc_q    <= div_q && (b_q == '0);
            rdy_q    <= 1'b1;
            state_q  <= StDone;
          end
`endif
        end
        StRun: begin
          if (div_q) begin
            rem_q <= {(add_sum[WIDTH+1] ? add_sum[WIDTH-1:0] : rem_q[WIDTH-1:0]),
                      prod_q[WIDTH-1]};
            prod_q[WIDTH-1:0] <= {prod_q[WIDTH-2:0], add_sum[WIDTH+1]};
          end else begin
            prod_q <= {add_sum[WIDTH:0], prod_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH-1)) begin
            cnt_q   <= '0;
            state_q <= StFixup;
          end
        end
        StFixup: begin
          if (div_q) begin
            result_q <= div0_q ? '0 : (sign_q ? add_sum[WIDTH-1:0] : prod_q[WIDTH-1:0]);
            exc_q    <= div0_q | ovf_q;
          end else begin
            result_q <= prod_signed[WIDTH-1:0];
            exc_q    <= mult_ovf;
          end
          rdy_q   <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: vector table plus abort and mid-operation reset sequences.
module tb_multdiv_ctrl;
  localparam int unsigned WIDTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multdiv_ctrl_if #(.WIDTH(WIDTH)) bus ();

  multdiv_ctrl #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        exc;
    int          start;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rdy_seen = 0;
  int   op_id    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_EARLY_ZERO_EN
    if ((a == 32'h0) || (b == 32'h0)) return 2;
`endif
    return WIDTH + 3;
  endfunction

  // Scoreboard consumer and busy-window check.
  always @(negedge clock) begin
    if (reset) begin
      if (sb.size() == 0)
        check("busy when idle", {31'b0, bus.busy}, 32'd0);
      else if (cyc > sb[0].start)
        check($sformatf("op%0d busy", sb[0].id), {31'b0, bus.busy}, 32'd1);
      if (bus.data_resultRDY) begin
        rdy_seen++;
        if (sb.size() == 0) begin
          check("resultRDY with nothing pending", {31'b0, bus.data_resultRDY}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("op%0d result", e.id), bus.data_result, e.res);
          check($sformatf("op%0d exception", e.id), {31'b0, bus.data_exception},
                {31'b0, e.exc});
          check($sformatf("op%0d latency", e.id), cyc - e.start, e.due - e.start);
        end
      end
    end
  end

  task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic exc,
                          input bit aborts);
    exp_t e;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    if (aborts && (sb.size() != 0)) void'(sb.pop_back());
    e.id    = op_id;
    e.res   = res;
    e.exc   = exc;
    e.start = cyc;
    e.due   = cyc + lat(a, b);
    op_id++;
    sb.push_back(e);
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0) && (n < 60)) begin
      @(posedge clock);
      n++;
    end
    check({name, " completes"}, {31'b0, sb.size() == 0}, 32'd1);
    if (sb.size() != 0) sb.delete();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  vec_t vecs[16];
  int   base;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0006, 32'h0000_0002, 32'h0000_000C, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_001E, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0009, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0};

    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    repeat (3) @(posedge clock);
    #1;
    check("reset result", bus.data_result, 32'd0);
    check("reset exception", {31'b0, bus.data_exception}, 32'd0);
    check("reset resultRDY", {31'b0, bus.data_resultRDY}, 32'd0);
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      start_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, 1'b0);
      wait_done($sformatf("vec%0d", i));
    end

    // MULT 3*4 aborted by DIV 20/5 ten cycles later: exactly one result, from the DIV.
    base = rdy_seen;
    start_op(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);
    repeat (8) @(posedge clock);
    start_op(1'b0, 1'b1, 32'd20, 32'd5, 32'd4, 1'b0, 1'b1);
    wait_done("abort restart");
    check("abort single resultRDY", rdy_seen - base, 32'd1);

    // Asynchronous reset in the middle of a MULT.
    start_op(1'b1, 1'b0, 32'd100, 32'd3, 32'd300, 1'b0, 1'b0);
    repeat (11) @(posedge clock);
    #3;
    reset = 1'b0;
    sb.delete();
    #1;
    check("mid reset result", bus.data_result, 32'd0);
    check("mid reset exception", {31'b0, bus.data_exception}, 32'd0);
    check("mid reset resultRDY", {31'b0, bus.data_resultRDY}, 32'd0);
    check("mid reset busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    base = rdy_seen;
    repeat (45) @(posedge clock);
    check("no resultRDY after reset", rdy_seen - base, 32'd0);
    start_op(1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
    wait_done("mult after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Iterative signed multiply/divide unit for the execute stage. It sequences a shared 32-bit adder and inverter datapath over WIDTH cycles.
- It is started by one-cycle ctrl pulses from the pipeline control. It returns a result with a one-cycle ready pulse.
- The pipeline stalls on it while it is busy.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
ctrl_MULT  input  1  one-cycle start pulse, signed multiply
ctrl_DIV  input  1  one-cycle start pulse, signed divide (quotient only)
data_operandA  input  WIDTH  multiplicand/dividend; sampled on the start cycle only
data_operandB  input  WIDTH  multiplier/divisor; sampled on the start cycle only
data_result  output  WIDTH  product low word or quotient; held until the next start
data_exception  output  1  overflow / divide-by-zero flag; valid with data_result
data_resultRDY  output  1  one-cycle pulse when data_result is valid
busy  output  1  high from the cycle after start through the DONE cycle

Behaviour:
- Reset (reset=0, any time, including mid-operation):
  - State goes to IDLE.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Iteration counter=0. Internal registers are cleared.
- States: IDLE -> SETUP -> RUN -> FIXUP -> DONE -> IDLE.
- Start cycle N (ctrl_MULT or ctrl_DIV high in any state):
  - Latch operands and the op type.
  - Go to SETUP at N+1.
- Simultaneous ctrl_MULT and ctrl_DIV: MULT wins.
- A start in any non-IDLE state aborts the current operation and restarts with the new operands.
  - No resultRDY is emitted for the aborted operation.
  - data_result keeps its previous value until the new DONE.
- SETUP (N+1):
  - Record result sign = A[msb] XOR B[msb].
  - Replace negative operands with their magnitude (bitwise invert + 1 through the shared adder).
  - Record exception preconditions: divisor==0, and A==INT_MIN with B==-1 for DIV.
- RUN (N+2 .. N+WIDTH+1, exactly WIDTH cycles; counter 0..WIDTH-1, exits at WIDTH-1):
  - MULT: shift-add on a 2*WIDTH product register, one multiplier bit per cycle, LSB first.
  - DIV: restoring division, one quotient bit per cycle, MSB first. The remainder register is WIDTH+1 bits; trial subtract uses the same adder.
- FIXUP (N+WIDTH+2):
  - Negate the magnitude result if the sign bit is set.
  - MULT exception = 1 if the signed 2*WIDTH product is not representable in WIDTH bits, i.e. upper WIDTH+1 bits not all equal.
  - DIV rounds toward zero; the remainder is discarded.
- DONE (N+WIDTH+3):
  - data_result and data_exception update; data_resultRDY=1 for exactly this cycle.
  - busy=1 in this cycle; next state IDLE, unless a start arrives in the same cycle (restart).
- Total latency: start at N -> resultRDY at N+WIDTH+3 (N+35 for WIDTH=32). Latency is fixed for all operands, including exceptions.
- Divide by zero: data_result=0, data_exception=1.
- INT_MIN / -1: data_result=INT_MIN (0x80000000), data_exception=1.
- MULT overflow: data_result = low WIDTH bits of the true product, data_exception=1.
- Zero operands need no special handling; the result is 0 and exception is 0 (except divide by zero).

Optional Feature:
MULTDIV_EARLY_ZERO_EN
- Defined:
  - In SETUP, if MULT has A==0 or B==0, or DIV has A==0 or B==0, skip RUN and FIXUP.
  - DONE occurs at N+2, so resultRDY fires at N+2.
  - Result is 0; exception=1 only for divide by zero.
- Undefined: fixed latency WIDTH+3 for every operation, as above.

Test Plan:
- MULT A=7, B=0xFFFFFFFD (-3), pulse at N -> resultRDY only at N+35, result=0xFFFFFFEB, exception=0, busy high N+1..N+35.
- DIV A=100, B=0xFFFFFFF9 (-7) -> result=0xFFFFFFF2 (-14), exception=0 at N+35. Also A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
- DIV A=5, B=0 -> result=0, exception=1 at N+35 (N+2 with MULTDIV_EARLY_ZERO_EN); MULT A=0x00010000, B=0x00010000 -> result=0, exception=1.
- MULT 3*4 started at N, then DIV 20/5 pulse at N+10 -> no resultRDY at N+35, single resultRDY at N+45 with result=4. ctrl_MULT and ctrl_DIV together with A=6, B=2 -> result=12.
- MULT started at N, reset=0 asserted asynchronously at N+12 for one cycle -> all outputs 0 immediately, no resultRDY afterwards; new MULT 2*2 then completes normally with result=4.
